// File: rtl/register_file_pkg.sv
// Shared constants for register_file: reserved register addresses, their reset
// values and the bit-field layout of the UART configuration register.
package register_file_pkg;

    // Reserved register addresses exposed as live outputs
    localparam int unsigned OPERAND_A_ADDRESS      = 0;
    localparam int unsigned OPERAND_B_ADDRESS      = 1;
    localparam int unsigned UART_CONFIG_ADDRESS    = 2;
    localparam int unsigned DIVISION_RATIO_ADDRESS = 3;

    // Reset values: prescale 32, even parity, parity enabled; divide by 32
    localparam logic [7:0] UART_CONFIG_DEFAULT    = 8'h81;
    localparam logic [7:0] DIVISION_RATIO_DEFAULT = 8'h20;

    // UART_config bit fields
    localparam int unsigned UART_CFG_PARITY_EN_BIT   = 0;
    localparam int unsigned UART_CFG_PARITY_TYPE_BIT = 1;
    localparam int unsigned UART_CFG_PRESCALE_LSB    = 2;
    localparam int unsigned UART_CFG_PRESCALE_MSB    = 7;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// register_file: register array sitting behind the UART receive controller.
// Executes single-cycle write/read requests; reads return registered data with
// a one-cycle valid strobe. Registers 0..3 are tapped continuously as ALU
// operands, UART configuration and clock-divider ratio.
//
// Ports:
//   clk, reset (async, active-high)
//   address, write_enable, write_data, read_enable   - request from controller
//   read_data, read_data_valid                       - registered read result
//   operand_A, operand_B, UART_config, division_ratio - live register taps
//   write_rejected (REGISTER_FILE_CONFIG_LOCK_EN only) - discarded write strobe
//
// Build option: define REGISTER_FILE_CONFIG_LOCK_EN to make registers 2 and 3
// read-only to the controller.
module register_file
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH          = 8,
    parameter int unsigned REGISTER_FILE_DEPTH = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [$clog2(REGISTER_FILE_DEPTH)-1:0] address,
    input  logic                                   write_enable,
    input  logic [DATA_WIDTH-1:0]                  write_data,
    input  logic                                   read_enable,
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
    output logic                                   write_rejected,
`endif
    output logic [DATA_WIDTH-1:0]                  read_data,
    output logic                                   read_data_valid,
    output logic [DATA_WIDTH-1:0]                  operand_A,
    output logic [DATA_WIDTH-1:0]                  operand_B,
    output logic [DATA_WIDTH-1:0]                  UART_config,
    output logic [DATA_WIDTH-1:0]                  division_ratio
);

    localparam int unsigned ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    logic [DATA_WIDTH-1:0] regs_q [REGISTER_FILE_DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [REGISTER_FILE_DEPTH];
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_data_valid_q, read_data_valid_d;
    logic                  addr_in_range;

    // Reset value of each register index
    function automatic logic [DATA_WIDTH-1:0] reset_value(input int unsigned idx);
        if (idx == UART_CONFIG_ADDRESS)    return DATA_WIDTH'(UART_CONFIG_DEFAULT);
        if (idx == DIVISION_RATIO_ADDRESS) return DATA_WIDTH'(DIVISION_RATIO_DEFAULT);
        return '0;
    endfunction

    // Every address code is legal for a power-of-two depth; otherwise bound it
    if (REGISTER_FILE_DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
        assign addr_in_range = 1'b1;
    end else begin : g_partial_range
        assign addr_in_range = (32'(address) < REGISTER_FILE_DEPTH);
    end

    // ---------------- write port ----------------
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
    logic write_rejected_q, write_rejected_d;
`endif

    always_comb begin
        regs_d = regs_q;
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
        write_rejected_d = 1'b0;
        if (write_enable && addr_in_range) begin
            if (32'(address) == UART_CONFIG_ADDRESS ||
                32'(address) == DIVISION_RATIO_ADDRESS) begin
                write_rejected_d = 1'b1;
            end else begin
                regs_d[address] = write_data;
            end
        end
`else
        if (write_enable && addr_in_range) begin
            regs_d[address] = write_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(REGISTER_FILE_DEPTH); i++) begin
                regs_q[i] <= reset_value(32'(i));
            end
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
            write_rejected_q <= 1'b0;
`endif
        end else begin
            regs_q <= regs_d;
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
            write_rejected_q <= write_rejected_d;
`endif
        end
    end

    // ---------------- read port ----------------
    // A simultaneous write takes priority; the read is dropped and data holds
    always_comb begin
        read_data_d       = read_data_q;
        read_data_valid_d = 1'b0;
        if (read_enable && !write_enable) begin
            read_data_valid_d = 1'b1;
            read_data_d       = addr_in_range ? regs_q[address] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q       <= '0;
            read_data_valid_q <= 1'b0;
        end else begin
            read_data_q       <= read_data_d;
            read_data_valid_q <= read_data_valid_d;
        end
    end

    // ---------------- outputs ----------------
    assign read_data       = read_data_q;
    assign read_data_valid = read_data_valid_q;
    assign operand_A       = regs_q[OPERAND_A_ADDRESS];
    assign operand_B       = regs_q[OPERAND_B_ADDRESS];
    assign UART_config     = regs_q[UART_CONFIG_ADDRESS];
    assign division_ratio  = regs_q[DIVISION_RATIO_ADDRESS];
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
    assign write_rejected  = write_rejected_q;
`endif

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. Stimulus is driven on the falling
// edge; a scoreboard queue holds expected read data and is drained by a
// monitor just after each rising edge. A reference array tracks register state.
module tb_register_file;
    import register_file_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          write_enable;
    logic [DW-1:0] write_data;
    logic          read_enable;
    logic [DW-1:0] read_data;
    logic          read_data_valid;
    logic [DW-1:0] operand_A, operand_B, UART_config, division_ratio;
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
    logic          write_rejected;
    logic          exp_rej;
`endif

    register_file #(.DATA_WIDTH(DW), .REGISTER_FILE_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .write_enable    (write_enable),
        .write_data      (write_data),
        .read_enable     (read_enable),
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
        .write_rejected  (write_rejected),
`endif
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .operand_A       (operand_A),
        .operand_B       (operand_B),
        .UART_config     (UART_config),
        .division_ratio  (division_ratio)
    );

    always #5 clk = ~clk;

    int unsigned   tests_run = 0;
    int unsigned   tests_failed = 0;
    logic [DW-1:0] exp_regs [DEPTH];
    logic [DW-1:0] sb_q [$];
    logic [DW-1:0] last_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) exp_regs[i] = 8'h00;
        exp_regs[2] = 8'h81;
        exp_regs[3] = 8'h20;
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
        exp_rej = 1'b0;
`endif
    endtask

    // Drive one request on the falling edge and update the reference model
    task automatic drive(input logic we, input logic re, input int unsigned a, input logic [DW-1:0] d);
        @(negedge clk);
        write_enable = we;
        read_enable  = re;
        address      = AW'(a);
        write_data   = d;
        if (re && !we) sb_q.push_back(exp_regs[a]);
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
        exp_rej = we && (a == 2 || a == 3);
        if (we && !(a == 2 || a == 3)) exp_regs[a] = d;
`else
        if (we) exp_regs[a] = d;
`endif
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 8'h00);
    endtask

    // Monitor: scoreboard pop on valid, hold check otherwise, live taps every cycle
    always @(posedge clk) begin
        #1;
        if (reset) begin
            sb_q.delete();
            last_rd = '0;
        end else begin
            if (sb_q.size() > 0) begin
                logic [DW-1:0] e;
                e = sb_q.pop_front();
                check_eq("rd_valid", 32'(read_data_valid), 32'd1);
                check_eq("rd_data", 32'(read_data), 32'(e));
                last_rd = e;
            end else begin
                check_eq("rd_valid_idle", 32'(read_data_valid), 32'd0);
                check_eq("rd_data_hold", 32'(read_data), 32'(last_rd));
            end
            check_eq("operand_A", 32'(operand_A), 32'(exp_regs[0]));
            check_eq("operand_B", 32'(operand_B), 32'(exp_regs[1]));
            check_eq("UART_config", 32'(UART_config), 32'(exp_regs[2]));
            check_eq("division_ratio", 32'(division_ratio), 32'(exp_regs[3]));
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
            check_eq("write_rejected", 32'(write_rejected), 32'(exp_rej));
`endif
        end
    end

    initial begin
        reset = 1'b1; address = '0; write_enable = 1'b0; read_enable = 1'b0; write_data = '0;
        last_rd = '0;
        model_reset();
        #2;
        check_eq("rst_read_data", 32'(read_data), 32'h00);
        check_eq("rst_valid", 32'(read_data_valid), 32'd0);
        check_eq("rst_UART_config", 32'(UART_config), 32'h81);
        check_eq("rst_division_ratio", 32'(division_ratio), 32'h20);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // Back-to-back reads of reserved registers: 00 00 81 20
        for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, a, 8'h00);
        idle(1);

        // Operand writes
        drive(1'b1, 1'b0, 0, 8'h09);
        drive(1'b1, 1'b0, 1, 8'h0A);
        idle(1);
        check_eq("operand_A_0x09", 32'(operand_A), 32'h09);
        check_eq("operand_B_0x0A", 32'(operand_B), 32'h0A);

        // Write then read on the following cycle
        drive(1'b1, 1'b0, 13, 8'hCF);
        drive(1'b0, 1'b1, 13, 8'h00);
        idle(1);

        // Simultaneous write and read: write wins, read dropped
        drive(1'b1, 1'b1, 5, 8'h55);
        idle(1);
        drive(1'b0, 1'b1, 5, 8'h00);
        idle(1);

        // Write to divider ratio register
        drive(1'b1, 1'b0, 3, 8'h40);
        idle(1);
`ifdef REGISTER_FILE_CONFIG_LOCK_EN
        check_eq("div_ratio_locked", 32'(division_ratio), 32'h20);
`else
        check_eq("div_ratio_written", 32'(division_ratio), 32'h40);
`endif
        drive(1'b0, 1'b1, 3, 8'h00);

        // Randomised mix of requests
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, DEPTH - 1), DW'($urandom));
        end
        idle(2);

        // Async reset mid-cycle with a read strobe outstanding
        drive(1'b1, 1'b0, 2, 8'h77);
        drive(1'b0, 1'b1, 2, 8'h00);
        @(posedge clk);
        #3;
        reset = 1'b1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        model_reset();
        #1;
        check_eq("async_rst_UART_config", 32'(UART_config), 32'h81);
        check_eq("async_rst_valid", 32'(read_data_valid), 32'd0);
        check_eq("async_rst_read_data", 32'(read_data), 32'h00);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        drive(1'b0, 1'b1, 2, 8'h00);
        idle(2);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_register_file

// File: doc/register_file.md
# register_file

Parameterised register file that sits directly downstream of the UART receiver controller. It executes the controller's write and read requests and returns read data with a valid strobe for the transmit path. It also exposes four reserved registers continuously: ALU operands A and B, the UART configuration byte, and the clock-divider ratio.

## Interface
Parameters:
- DATA_WIDTH, 8, width of every register and of the data buses
- REGISTER_FILE_DEPTH, 16, number of registers; address width is $clog2(REGISTER_FILE_DEPTH)

Ports:
- clk  input  1  reference clock; all state is updated on its rising edge
- reset  input  1  asynchronous, active-high; restores every register and output to its reset value
- address  input  $clog2(REGISTER_FILE_DEPTH)  register index for the current access
- write_enable  input  1  write write_data to address on this edge
- write_data  input  DATA_WIDTH  data to be written
- read_enable  input  1  read address on this edge
- read_data  output  DATA_WIDTH  registered read result
- read_data_valid  output  1  one-cycle strobe qualifying read_data
- operand_A  output  DATA_WIDTH  live contents of register 0
- operand_B  output  DATA_WIDTH  live contents of register 1
- UART_config  output  DATA_WIDTH  live contents of register 2: bit0 parity enable, bit1 parity type, bits[7:2] prescale
- division_ratio  output  DATA_WIDTH  live contents of register 3
- write_rejected  output  1  present only with REGISTER_FILE_CONFIG_LOCK_EN (see Configuration)

## Operation
- Storage is an array of REGISTER_FILE_DEPTH entries, each DATA_WIDTH bits wide.
- Reset values:
  - register 0 = 0x00
  - register 1 = 0x00
  - register 2 = 0x81 (prescale 32, even parity, parity enabled)
  - register 3 = 0x20
  - all other registers = 0x00
  - read_data = 0x00, read_data_valid = 0, write_rejected = 0
- Write: when write_enable is 1 at a rising edge, register[address] <= write_data. The new value appears on the matching reserved output after that same edge.
- Read: when read_enable is 1 and write_enable is 0 at a rising edge:
  - read_data <= register[address]
  - read_data_valid <= 1 for exactly that one cycle
- Write and read asserted together: the write wins and the read is dropped. read_data_valid stays 0 and read_data holds its value.
- Without a read, read_data_valid is 0 and read_data holds its last value.
- Back-to-back reads on consecutive cycles give consecutive valid strobes, each with its own data.
- A read on the cycle after a write to the same address returns the newly written value.
- Every address width value is a legal index when REGISTER_FILE_DEPTH is a power of two. For any other depth, writes to out-of-range addresses are ignored and reads of them return 0x00 with read_data_valid still pulsed.
- Reset asserted mid-operation immediately (asynchronously) forces all reset values and clears any pending strobe.

## Timing
- Write latency: 1 edge. The reserved outputs are direct register taps with no extra pipeline stage.
- Read latency: 1 edge. read_data and read_data_valid change together.
- No handshake back-pressure: every request is accepted on the edge where it is seen.
- Request inputs are single-cycle pulses from the controller. A request held high for N cycles is executed N times.

## Configuration
- Macro: REGISTER_FILE_CONFIG_LOCK_EN.
- Defined:
  - writes to registers 2 and 3 are discarded and the register keeps its value
  - write_rejected pulses 1 for one cycle, on the edge where the discarded write is seen
  - writes to all other addresses behave normally
- Undefined:
  - registers 2 and 3 are writable like any other register
  - the write_rejected port does not exist

## Structure
- Shared package holds:
  - reserved-address constants: OPERAND_A_ADDRESS=0, OPERAND_B_ADDRESS=1, UART_CONFIG_ADDRESS=2, DIVISION_RATIO_ADDRESS=3
  - reset-value constants: UART_CONFIG_DEFAULT=0x81, DIVISION_RATIO_DEFAULT=0x20
  - the UART_config bit-field positions
- Single flat module, no sub-module. The read port and write port are separate always blocks in the same file.

## Test plan
- Reset, then read addresses 0–3 on consecutive cycles -> read_data sequence 0x00, 0x00, 0x81, 0x20, each with a 1-cycle read_data_valid.
- Write 0x09 to address 0 and 0x0A to address 1 -> operand_A=0x09 and operand_B=0x0A one edge later; read_data_valid stays 0 throughout.
- Write 0xCF to address 13, then read address 13 on the next cycle -> read_data=0xCF with read_data_valid=1 for exactly one cycle.
- Assert write_enable (0x55) and read_enable together on address 5 -> register 5 = 0x55, read_data_valid=0, read_data unchanged.
- Write 0x40 to address 3 -> with REGISTER_FILE_CONFIG_LOCK_EN: division_ratio stays 0x20 and write_rejected pulses once; without it: division_ratio=0x40.
- Write 0x77 to address 2, then assert reset asynchronously mid-cycle -> UART_config returns to 0x81 and read_data_valid=0 before the next clock edge.
